// File: rtl/zjh_intc_pkg.sv
// rtl/zjh_intc_pkg.sv - shared sizes and FSM state type for the 8-channel interrupt controller
package zjh_intc_pkg;

  localparam int N_CH  = 8;
  localparam int VEC_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_SERV = 2'd2
  } state_t;

  function automatic logic [N_CH-1:0] vec_onehot(input logic [VEC_W-1:0] v);
    logic [N_CH-1:0] oh;
    oh    = '0;
    oh[v] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/zjh_prio_enc8.sv
// rtl/zjh_prio_enc8.sv - 8-input active-high priority encoder, highest index wins
module zjh_prio_enc8
  import zjh_intc_pkg::*;
(
  input  logic [N_CH-1:0]  in,
  output logic [VEC_W-1:0] idx,
  output logic             valid
);

  always_comb begin
    idx   = '0;
    valid = |in;
    // ascending scan so the last (highest) set bit overwrites lower ones
    for (int i = 0; i < N_CH; i++) begin
      if (in[i]) idx = i[VEC_W-1:0];
    end
  end

endmodule

// File: rtl/zjh_int_ctrl8.sv
// rtl/zjh_int_ctrl8.sv - edge-captured, maskable interrupt controller with irq/ack/eoi handshake
module zjh_int_ctrl8
  import zjh_intc_pkg::*;
#(
  parameter logic [N_CH-1:0] MASK_RST = 8'h00
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_CH-1:0]  req_n,
  input  logic             ei_n,
  input  logic             mask_we,
  input  logic [N_CH-1:0]  mask_din,
  input  logic             ack,
  input  logic             eoi,
  output logic             irq,
  output logic [VEC_W-1:0] vec,
  output logic             busy,
  output logic             gs,
  output logic [N_CH-1:0]  pend
);

  state_t            state_q, state_d;
  logic [N_CH-1:0]   req_n_d;
  logic [N_CH-1:0]   mask;
  logic [N_CH-1:0]   eff;
  logic [N_CH-1:0]   fall;
  logic [N_CH-1:0]   clr;
  logic [VEC_W-1:0]  enc;
  logic              enc_valid;
  logic [VEC_W-1:0]  vec_d;

  assign eff  = pend & ~mask;
  assign fall = req_n_d & ~req_n;

  zjh_prio_enc8 u_prio (
    .in    (eff),
    .idx   (enc),
    .valid (enc_valid)
  );

  always_comb begin
    state_d = state_q;
    vec_d   = vec;
    clr     = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (!ei_n && enc_valid) begin
          vec_d   = enc;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        // ack wins over a same-cycle ei_n withdrawal; latched vec is serviced even if now masked
        if (ack) begin
          clr     = vec_onehot(vec);
          state_d = ST_SERV;
        end else if (ei_n) begin
          state_d = ST_IDLE;
        end
      end
      ST_SERV: begin
        if (eoi) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      req_n_d <= '1;
      mask    <= MASK_RST;
      pend    <= '0;
      vec     <= '0;
      gs      <= 1'b0;
    end else begin
      state_q <= state_d;
      req_n_d <= req_n;
      if (mask_we) mask <= mask_din;
      // a new edge on the channel being cleared keeps it pending
      pend    <= (pend & ~clr) | fall;
      vec     <= vec_d;
      gs      <= |eff;
    end
  end

  assign irq  = (state_q == ST_REQ);
  assign busy = (state_q == ST_SERV);

endmodule

// File: tb/tb_zjh_int_ctrl8.sv
// tb/tb_zjh_int_ctrl8.sv - scoreboard bench for zjh_int_ctrl8 against a behavioural model
module tb_zjh_int_ctrl8;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req_n;
  logic       ei_n;
  logic       mask_we;
  logic [7:0] mask_din;
  logic       ack;
  logic       eoi;
  logic       irq;
  logic [2:0] vec;
  logic       busy;
  logic       gs;
  logic [7:0] pend;

  int total = 0;
  int bad   = 0;

  logic [13:0] exp_q[$];

  bit [7:0] m_pend, m_prev, m_mask;
  int       m_phase;
  int       m_vec;
  bit       m_gs;

  bit       irq_seen;

  always #5 clk = ~clk;

  zjh_int_ctrl8 dut (
    .clk      (clk),
    .rst      (rst),
    .req_n    (req_n),
    .ei_n     (ei_n),
    .mask_we  (mask_we),
    .mask_din (mask_din),
    .ack      (ack),
    .eoi      (eoi),
    .irq      (irq),
    .vec      (vec),
    .busy     (busy),
    .gs       (gs),
    .pend     (pend)
  );

  function automatic int highest(input bit [7:0] v);
    for (int i = 7; i >= 0; i--) if (v[i]) return i;
    return -1;
  endfunction

  task automatic model_edge();
    bit [7:0] eff;
    bit [7:0] np;
    if (rst) begin
      m_pend = 8'h00; m_prev = 8'hFF; m_mask = 8'h00;
      m_phase = 0; m_vec = 0; m_gs = 0;
      return;
    end
    eff = m_pend & ~m_mask;
    np  = m_pend;
    m_gs = (eff != 0);
    if (m_phase == 1 && ack) np[m_vec] = 1'b0;
    for (int i = 0; i < 8; i++) if (m_prev[i] && !req_n[i]) np[i] = 1'b1;
    case (m_phase)
      0: if (!ei_n && eff != 0) begin m_vec = highest(eff); m_phase = 1; end
      1: if (ack) m_phase = 2; else if (ei_n) m_phase = 0;
      default: if (eoi) m_phase = 0;
    endcase
    m_pend = np;
    if (mask_we) m_mask = mask_din;
    m_prev = req_n;
  endtask

  task automatic step(input bit r, input bit e, input bit mwe, input bit [7:0] md,
                      input bit a, input bit o);
    rst = r; ei_n = e; mask_we = mwe; mask_din = md; ack = a; eoi = o;
    model_edge();
    @(posedge clk);
    exp_q.push_back({m_phase == 1, m_vec[2:0], m_phase == 2, m_gs, m_pend});
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 0, 8'h00, 0, 0);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [13:0] e;
      e = exp_q.pop_front();
      total++;
      if ({irq, vec, busy, gs, pend} !== e) begin
        bad++;
        $display("FAIL outputs t=%0t got irq=%b vec=%0d busy=%b gs=%b pend=%h want irq=%b vec=%0d busy=%b gs=%b pend=%h",
                 $time, irq, vec, busy, gs, pend, e[13], e[12:10], e[9], e[8], e[7:0]);
      end
    end
  end

  initial begin
    req_n = 8'hFF; rst = 1; ei_n = 0; mask_we = 0; mask_din = 0; ack = 0; eoi = 0;
    #1;
    step(1, 0, 0, 8'h00, 0, 0);
    step(1, 0, 0, 8'h00, 0, 0);
    total++;
    if ({irq, vec, busy, gs, pend} !== 14'd0) begin
      bad++;
      $display("FAIL reset state t=%0t irq=%b vec=%0d busy=%b gs=%b pend=%h",
               $time, irq, vec, busy, gs, pend);
    end
    idle(6);

    req_n[5] = 1'b0;
    irq_seen = 1'b0;
    for (int w = 0; w < 3; w++) begin
      step(0, 0, 0, 8'h00, 0, 0);
      if (irq) irq_seen = 1'b1;
    end
    total++;
    if (!irq_seen) begin
      bad++;
      $display("FAIL timeout t=%0t irq not raised within 3 cycles of req_n[5] fall", $time);
    end
    step(0, 0, 0, 8'h00, 1, 0); idle(2);
    step(0, 0, 0, 8'h00, 0, 1); req_n = 8'hFF; idle(2);

    req_n[2] = 1'b0; req_n[6] = 1'b0; idle(3);
    step(0, 0, 0, 8'h00, 1, 0); step(0, 0, 0, 8'h00, 0, 1);
    idle(2);
    step(0, 0, 0, 8'h00, 1, 0); step(0, 0, 0, 8'h00, 0, 1);
    req_n = 8'hFF; idle(2);

    step(0, 0, 1, 8'h80, 0, 0);
    req_n[7] = 1'b0; idle(4);
    step(0, 0, 1, 8'h00, 0, 0); idle(3);
    step(0, 0, 0, 8'h00, 1, 0); step(0, 0, 0, 8'h00, 0, 1);
    req_n = 8'hFF; idle(2);

    req_n[3] = 1'b0; idle(3);
    step(0, 1, 0, 8'h00, 0, 0); step(0, 1, 0, 8'h00, 0, 0);
    idle(2);
    step(0, 1, 0, 8'h00, 1, 0); step(0, 0, 0, 8'h00, 0, 1);
    req_n = 8'hFF; idle(2);

    req_n[4] = 1'b0; idle(3);
    req_n[4] = 1'b1; idle(1);
    req_n[4] = 1'b0; step(0, 0, 0, 8'h00, 1, 0);
    step(0, 0, 0, 8'h00, 0, 1); idle(2);
    step(0, 0, 0, 8'h00, 1, 0); step(0, 0, 0, 8'h00, 0, 1);
    req_n = 8'hFF; idle(2);

    req_n[1] = 1'b0; req_n[3] = 1'b0; req_n[4] = 1'b0; idle(3);
    step(0, 0, 0, 8'h00, 1, 0);
    step(1, 0, 0, 8'h00, 0, 0);
    step(0, 0, 0, 8'h00, 1, 1);
    step(0, 0, 0, 8'h00, 0, 1);
    req_n = 8'hFF; idle(3);

    for (int k = 0; k < 3000; k++) begin
      bit r, e, mwe, a, o;
      bit [7:0] md;
      for (int i = 0; i < 8; i++) if ($urandom_range(0, 99) < 8) req_n[i] = ~req_n[i];
      r   = ($urandom_range(0, 999) < 5);
      e   = ($urandom_range(0, 99) < 15);
      mwe = ($urandom_range(0, 99) < 5);
      md  = 8'($urandom) & 8'($urandom);
      a   = ($urandom_range(0, 99) < 30);
      o   = ($urandom_range(0, 99) < 30);
      step(r, e, mwe, md, a, o);
    end

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
